// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum collector.
package psum_pkg;

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  localparam int DEF_MAC_NUM   = 256;
  localparam int DEF_PSUM_W    = 5;
  localparam int DEF_ACC_W     = 12;
  localparam int DEF_OUT_LANES = 16;

  // Returns {clamped, sum}; sum is limited to max_v.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) return {1'b1, max_v};
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/psum_lane_acc.sv
// One lane's saturating accumulator with a sticky per-tile saturation flag.
module psum_lane_acc
  import psum_pkg::*;
#(
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              add,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  acc_next,
  output logic              sat
);

  localparam logic [31:0] MAX_V = (32'd1 << ACC_W) - 32'd1;

  logic [32:0] res;
  logic        sat_next;
  logic        unused_hi;

  // acc_next is exported so the top can register beat 0 on the accept edge.
  always_comb begin
    res      = sat_add(32'(acc), 32'(psum), MAX_V);
    acc_next = acc;
    sat_next = sat;
    if (load) begin
      acc_next = ACC_W'(psum);
      sat_next = 1'b0;
    end else if (add) begin
      acc_next = res[ACC_W-1:0];
      sat_next = sat | res[32];
    end
  end

  assign unused_hi = ^res[31:ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sat <= 1'b0;
    end else begin
      acc <= acc_next;
      sat <= sat_next;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates MAC partial sums across passes and drains them as beats.
// Optional PSUM_BINARIZE_EN: each output lane becomes (acc >= threshold).
module psum_collector
  import psum_pkg::*;
#(
  parameter int MAC_NUM   = DEF_MAC_NUM,
  parameter int PSUM_W    = DEF_PSUM_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_LANES = DEF_OUT_LANES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PSUM_W*MAC_NUM-1:0]   psum_in,
  input  logic                        psum_valid,
  output logic                        psum_ready,
  input  logic                        first_pass,
  input  logic                        last_pass,
`ifdef PSUM_BINARIZE_EN
  output logic [OUT_LANES-1:0]        out_data,
  input  logic [ACC_W-1:0]            threshold,
`else
  output logic [OUT_LANES*ACC_W-1:0]  out_data,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        sat
);

  localparam int BEATS = MAC_NUM / OUT_LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);
`ifdef PSUM_BINARIZE_EN
  localparam int OUT_W = OUT_LANES;
`else
  localparam int OUT_W = OUT_LANES * ACC_W;
`endif

  state_t                              state, state_n;
  logic [CNT_W-1:0]                    idx, idx_n;
  logic                                accept, load_out;
  logic [MAC_NUM-1:0][ACC_W-1:0]       acc, acc_next;
  logic [MAC_NUM-1:0]                  lane_sat;
  logic [BEATS-1:0][OUT_LANES-1:0][ACC_W-1:0] src;
  logic [OUT_LANES-1:0][ACC_W-1:0]     beat;
  logic [OUT_W-1:0]                    out_d;

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    psum_lane_acc #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (accept & first_pass),
      .add      (accept & ~first_pass),
      .psum     (psum_in[i*PSUM_W +: PSUM_W]),
      .acc      (acc[i]),
      .acc_next (acc_next[i]),
      .sat      (lane_sat[i])
    );
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    load_out   = 1'b0;
    case (state)
      ACCUM: begin
        psum_ready = 1'b1;
        accept     = psum_valid;
        if (psum_valid && last_pass) begin
          state_n  = DRAIN;
          idx_n    = '0;
          load_out = 1'b1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_n = ACCUM;
          end else begin
            idx_n    = idx + 1'b1;
            load_out = 1'b1;
          end
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  // acc_next equals acc outside an accept, so one source serves both the
  // beat-0 load on the accept edge and every later beat.
  assign src  = acc_next;
  assign beat = src[idx_n];

`ifdef PSUM_BINARIZE_EN
  always_comb begin
    out_d = '0;
    for (int j = 0; j < OUT_LANES; j++) out_d[j] = (beat[j] >= threshold);
  end
`else
  assign out_d = beat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      idx      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (load_out) begin
        out_data <= out_d;
        out_last <= (idx_n == LAST_IDX);
      end
    end
  end

  assign sat = |lane_sat;

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: random passes against a per-lane arithmetic model.
module tb_psum_collector;

  localparam int MAC_NUM   = 256;
  localparam int PSUM_W    = 5;
  localparam int ACC_W     = 6;
  localparam int OUT_LANES = 16;
  localparam int BEATS     = MAC_NUM / OUT_LANES;
  localparam int MAXV      = (1 << ACC_W) - 1;
`ifdef PSUM_BINARIZE_EN
  localparam int OUT_W = OUT_LANES;
`else
  localparam int OUT_W = OUT_LANES * ACC_W;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic [PSUM_W*MAC_NUM-1:0]  psum_in;
  logic                       psum_valid, psum_ready, first_pass, last_pass;
  logic [OUT_W-1:0]           out_data;
  logic                       out_valid, out_ready, out_last, sat;
  logic [ACC_W-1:0]           threshold;

  always #5 clk = ~clk;

  psum_collector #(
    .MAC_NUM(MAC_NUM), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_LANES(OUT_LANES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .first_pass (first_pass),
    .last_pass  (last_pass),
    .out_data   (out_data),
`ifdef PSUM_BINARIZE_EN
    .threshold  (threshold),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .sat        (sat)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int macc[MAC_NUM];
  bit msat;
  int pv[MAC_NUM];

  task automatic fill(input int v);
    for (int i = 0; i < MAC_NUM; i++) pv[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < MAC_NUM; i++) pv[i] = $urandom_range(0, 25);
  endtask

  task automatic put_psum();
    for (int i = 0; i < MAC_NUM; i++) psum_in[i*PSUM_W +: PSUM_W] = PSUM_W'(pv[i]);
  endtask

  task automatic model_pass(input bit first);
    if (first) msat = 1'b0;
    for (int i = 0; i < MAC_NUM; i++) begin
      if (first) macc[i] = pv[i];
      else if (macc[i] + pv[i] > MAXV) begin
        macc[i] = MAXV;
        msat    = 1'b1;
      end else macc[i] = macc[i] + pv[i];
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_beat(input int b);
    logic [OUT_W-1:0] e;
    e = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
`ifdef PSUM_BINARIZE_EN
      e[j] = (macc[b*OUT_LANES+j] >= int'(threshold));
`else
      e[j*ACC_W +: ACC_W] = ACC_W'(macc[b*OUT_LANES+j]);
`endif
    end
    return e;
  endfunction

  // Called at a negedge with the collector in ACCUM; returns one negedge later.
  task automatic send_pass(input bit first, input bit last, input string name);
    put_psum();
    psum_valid = 1'b1; first_pass = first; last_pass = last;
    n_tests++;
    if (psum_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready: got %b expected 1", name, psum_ready);
    end
    @(negedge clk);
    psum_valid = 1'b0; first_pass = 1'b0; last_pass = 1'b0;
    model_pass(first);
    n_tests++;
    if (sat !== msat) begin
      n_fail++; $display("FAIL %s sat: got %b expected %b", name, sat, msat);
    end
    if (last) begin
      n_tests++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL %s valid_after_accept: got %b expected 1", name, out_valid);
      end
    end
  endtask

  // Consumes beats; stalls stall_n cycles on stall_beat; returns early with
  // out_ready low when beat stop_idx is pending.
  task automatic drain(input int stall_beat, input int stall_n, input int stop_idx,
                       input string name);
    int idx = 0, hs = 0, cyc = 0, st = 0;
    while (hs < BEATS && cyc < 300) begin
      if (out_valid === 1'b1) begin
        if (idx == stop_idx) begin
          out_ready = 1'b0;
          return;
        end
        n_tests++;
        if (out_data !== exp_beat(idx)) begin
          n_fail++;
          $display("FAIL %s beat %0d data: got %h expected %h", name, idx, out_data, exp_beat(idx));
        end
        n_tests++;
        if (out_last !== (idx == BEATS - 1)) begin
          n_fail++; $display("FAIL %s beat %0d last: got %b", name, idx, out_last);
        end
        if (idx == stall_beat && st < stall_n) begin
          out_ready = 1'b0; st++;
        end else begin
          out_ready = 1'b1; hs++; idx++;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    n_tests++;
    if (hs != BEATS || cyc != BEATS + stall_n) begin
      n_fail++;
      $display("FAIL %s handshakes: got %0d in %0d cycles expected %0d in %0d",
               name, hs, cyc, BEATS, BEATS + stall_n);
    end
    n_tests++;
    if (out_valid !== 1'b0 || psum_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s post_drain: valid %b ready %b expected 0 1", name, out_valid, psum_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; psum_valid = 1'b0; first_pass = 1'b0; last_pass = 1'b0;
    out_ready = 1'b0; psum_in = '0; threshold = ACC_W'(13);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < MAC_NUM; i++) macc[i] = 0;
    msat = 1'b0;
    n_tests++;
    if (psum_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_data !== '0 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ready %b valid %b last %b data %h sat %b expected 1 0 0 0 0",
               psum_ready, out_valid, out_last, out_data, sat);
    end
  endtask

  task automatic test_single_pass();
    fill(7);
    send_pass(1'b1, 1'b1, "single");
    drain(-1, 0, -1, "single");
  endtask

  task automatic test_multi_pass();
    fill(25); send_pass(1'b1, 1'b0, "multi0");
    fill(25); send_pass(1'b0, 1'b0, "multi1");
    fill(3);  send_pass(1'b0, 1'b1, "multi2");
    n_tests++;
    if (sat !== 1'b0) begin
      n_fail++; $display("FAIL multi sat: got %b expected 0", sat);
    end
    drain(-1, 0, -1, "multi");
  endtask

  task automatic test_saturation();
    fill(25); send_pass(1'b1, 1'b0, "sat0");
    fill(25); send_pass(1'b0, 1'b0, "sat1");
    fill(25); send_pass(1'b0, 1'b1, "sat2");
    n_tests++;
    if (sat !== 1'b1) begin
      n_fail++; $display("FAIL sat_set: got %b expected 1", sat);
    end
    drain(-1, 0, -1, "sat");
    fill(4); send_pass(1'b1, 1'b1, "sat_clear");
    n_tests++;
    if (sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear: got %b expected 0", sat);
    end
    drain(-1, 0, -1, "sat_clear");
  endtask

  task automatic test_backpressure();
    fill_rand(); send_pass(1'b1, 1'b1, "bp");
    drain(3, 5, -1, "bp");
  endtask

  task automatic test_valid_in_drain();
    fill_rand(); send_pass(1'b1, 1'b1, "vid");
    fill(9); put_psum();
    psum_valid = 1'b1;
    n_tests++;
    if (psum_ready !== 1'b0) begin
      n_fail++; $display("FAIL vid ready_in_drain: got %b expected 0", psum_ready);
    end
    drain(-1, 0, -1, "vid");
    @(negedge clk);
    psum_valid = 1'b0;
    model_pass(1'b0);
    fill(0); send_pass(1'b0, 1'b1, "vid_late");
    drain(-1, 0, -1, "vid_late");
  endtask

  task automatic test_reset_mid_drain();
    fill_rand(); send_pass(1'b1, 1'b1, "rmd");
    drain(-1, 0, 7, "rmd");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < MAC_NUM; i++) macc[i] = 0;
    msat = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || psum_ready !== 1'b1 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL rmd state: valid %b ready %b sat %b expected 0 1 0", out_valid, psum_ready, sat);
    end
    fill(5); send_pass(1'b0, 1'b1, "rmd_after");
    drain(-1, 0, -1, "rmd_after");
  endtask

`ifdef PSUM_BINARIZE_EN
  task automatic test_binarize();
    threshold = ACC_W'(13);
    for (int i = 0; i < MAC_NUM; i++) pv[i] = ($urandom_range(0, 1) != 0) ? 13 : 12;
    send_pass(1'b1, 1'b1, "bin");
    drain(-1, 0, -1, "bin");
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int np;
      np = $urandom_range(1, 3);
`ifdef PSUM_BINARIZE_EN
      threshold = ACC_W'($urandom_range(0, MAXV));
`endif
      for (int k = 0; k < np; k++) begin
        fill_rand();
        send_pass(k == 0, k == np - 1, "rand");
      end
      drain($urandom_range(0, BEATS - 1), $urandom_range(0, 3), -1, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_saturation();
    test_backpressure();
    test_valid_in_drain();
    test_reset_mid_drain();
`ifdef PSUM_BINARIZE_EN
    test_binarize();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
